// File: rtl/mem_cmd_ctrl.sv
// rtl/mem_cmd_ctrl.sv - UART byte-command front end driving a word-wide memory
//
// Purpose: decodes byte commands from a UART receiver and turns them into
// single-word memory writes or reads. A read returns the word on the UART
// transmit side, most significant byte first.
//   write: 0xA5, addr, NBYTES data bytes (MSB first)
//   read : 0x5A, addr -> NBYTES response bytes (MSB first)
//   Any other opcode in IDLE pulses cmd_err for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_valid   command byte and its one-cycle strobe
//   tx_data, tx_valid,  response byte, valid, and transmitter ready
//   tx_ready
//   write_En, read_En   one-cycle memory strobes (never both high)
//   Address, Data_in    memory address / write data, held between strobes
//   Data_out, Valid_out memory read data and its valid
//   busy, cmd_err       not-IDLE flag, one-cycle error pulse
//
// Optional feature: MEM_CMD_CTRL_TIMEOUT_EN -- abandons a read with a cmd_err
// pulse if Valid_out does not arrive within 16 cycles of entering WAIT_VALID.

module mem_cmd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         write_En,
  output logic                         read_En,
  output logic [$clog2(MEM_DEPTH)-1:0] Address,
  output logic [DATA_WIDTH-1:0]        Data_in,
  input  logic [DATA_WIDTH-1:0]        Data_out,
  input  logic                         Valid_out,
  output logic                         busy,
  output logic                         cmd_err
);

  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int NBYTES     = DATA_WIDTH / 8;
  localparam int CNT_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  localparam logic [7:0] OP_WRITE = 8'hA5;
  localparam logic [7:0] OP_READ  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    READ,
    WAIT_VALID,
    TX
  } state_t;

  state_t                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    cmd_err_q, cmd_err_d;
`ifdef MEM_CMD_CTRL_TIMEOUT_EN
  logic [3:0]              tmo_q, tmo_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      cmd_err_q <= 1'b0;
`ifdef MEM_CMD_CTRL_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      shift_q   <= shift_d;
      cmd_err_q <= cmd_err_d;
`ifdef MEM_CMD_CTRL_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    shift_d   = shift_q;
    cmd_err_d = 1'b0;
`ifdef MEM_CMD_CTRL_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    // Outputs are pure functions of registered state, so reset clears them.
    tx_valid = (state_q == TX);
    tx_data  = shift_q[DATA_WIDTH-1 -: 8];
    write_En = (state_q == WRITE);
    read_En  = (state_q == READ);
    busy     = (state_q != IDLE);
    cmd_err  = cmd_err_q;
    Address  = addr_q;
    Data_in  = wdata_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE) begin
            is_wr_d = 1'b1;
            state_d = ADDR;
          end else if (rx_data == OP_READ) begin
            is_wr_d = 1'b0;
            state_d = ADDR;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          // Size cast keeps only the low ADDR_WIDTH bits of the byte.
          addr_d  = ADDR_WIDTH'(rx_data);
          cnt_d   = '0;
          state_d = is_wr_q ? WDATA : READ;
        end
      end
      WDATA: begin
        if (rx_valid) begin
          wdata_d = DATA_WIDTH'({wdata_q, rx_data});
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        state_d = WAIT_VALID;
`ifdef MEM_CMD_CTRL_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT_VALID: begin
        if (Valid_out) begin
          shift_d = Data_out;
          cnt_d   = '0;
          state_d = TX;
        end
`ifdef MEM_CMD_CTRL_TIMEOUT_EN
        // tmo_q == 15 is the 16th cycle in this state; error shows next cycle.
        else if (tmo_q == 4'd15) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
`endif
      end
      TX: begin
        if (tx_ready) begin
          shift_d = DATA_WIDTH'({shift_q, 8'h00});
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// tb/tb_mem_cmd_ctrl.sv - self-checking bench for mem_cmd_ctrl

module tb_mem_cmd_ctrl;

  localparam int DW     = 32;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int NBYTES = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          write_En, read_En;
  logic [AW-1:0] Address;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] Data_out = '0;
  logic          Valid_out = 1'b0;
  logic          busy, cmd_err;

  mem_cmd_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .write_En(write_En), .read_En(read_En), .Address(Address),
    .Data_in(Data_in), .Data_out(Data_out), .Valid_out(Valid_out),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // External memory: one-cycle read latency, optional stall of Valid_out.
  logic [DW-1:0] mem [DEPTH];
  logic          mem_clear = 1'b1;
  logic          mem_stall = 1'b0;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_En) begin
      mem[Address] <= Data_in;
    end
    Valid_out <= read_En && !mem_stall;
    Data_out  <= mem[Address];
  end

  // Reference model: what the memory should contain after each command.
  logic [DW-1:0] model_mem [DEPTH];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready pattern: 0 always ready, 1 one-in-three, 2 random.
  int tx_mode = 0;
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 3;
      case (tx_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (ph == 0);
        default: tx_ready = 1'b1 & $urandom_range(0, 1);
      endcase
    end
  end

  // Monitor, sampled on the falling edge.
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic [7:0]    tx_q[$];
  int rd_cnt = 0, err_cnt = 0, both_err = 0, stab_err = 0;
  int rd_cyc = 0, first_tx_cyc = 0, err_cyc = 0;
  bit want_first = 0, prev_stall = 0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (write_En) begin
      wr_addr_q.push_back(Address);
      wr_data_q.push_back(Data_in);
    end
    if (read_En) begin
      rd_cnt++;
      rd_cyc = cyc;
      want_first = 1;
    end
    if (write_En && read_En) both_err++;
    if (tx_valid && want_first) begin
      first_tx_cyc = cyc;
      want_first = 0;
    end
    if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_err++;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (cmd_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check_eq({tag, "_idle_timeout"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [DW-1:0] d, input bit junk);
    send_byte(8'hA5);
    send_byte(a);
    for (int i = NBYTES - 1; i >= 0; i--) send_byte(d[i*8 +: 8]);
    if (junk) send_byte(8'h5A);   // lands in WRITE and must be ignored
    model_mem[a[AW-1:0]] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input bit junk);
    send_byte(8'h5A);
    send_byte(a);
    if (junk) send_byte(8'h77);   // lands in READ and must be ignored
  endtask

  function automatic logic [DW-1:0] tx_word();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < tx_q.size() && i < NBYTES; i++) w = {w[DW-9:0], tx_q[i]};
    return w;
  endfunction

  initial begin
    int rd_base, err_base;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_write_En", write_En, 0);
    check_eq("rst_read_En", read_En, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmd_err", cmd_err, 0);
    check_eq("rst_Address", Address, 0);
    check_eq("rst_Data_in", Data_in, 0);
    rst = 1'b0;
    mem_clear = 1'b0;
    @(posedge clk); #1;

    // Basic write
    clear_obs();
    do_write(8'h03, 32'hDEADBEEF, 0);
    wait_idle("wr1");
    check_eq("wr1_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check_eq("wr1_addr", wr_addr_q[0], 3);
      check_eq("wr1_data", wr_data_q[0], 32'hDEADBEEF);
    end
    check_eq("wr1_no_tx", tx_q.size(), 0);

    // Read back, always ready; latency read_En -> tx_valid is 2 cycles
    clear_obs();
    tx_mode = 0;
    rd_base = rd_cnt;
    do_read(8'h03, 0);
    wait_idle("rd1");
    check_eq("rd1_read_count", rd_cnt - rd_base, 1);
    check_eq("rd1_tx_count", tx_q.size(), NBYTES);
    check_eq("rd1_tx_word", tx_word(), 32'hDEADBEEF);
    check_eq("rd1_latency", first_tx_cyc - rd_cyc, 2);
    check_eq("rd1_busy", busy, 0);

    // Read with tx_ready one-in-three
    clear_obs();
    tx_mode = 1;
    do_read(8'h03, 0);
    wait_idle("rd2");
    check_eq("rd2_tx_count", tx_q.size(), NBYTES);
    check_eq("rd2_tx_word", tx_word(), 32'hDEADBEEF);
    check_eq("rd2_stable", stab_err, 0);
    tx_mode = 0;

    // Bad opcode then normal write
    clear_obs();
    err_base = err_cnt;
    send_byte(8'h77);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bad_err_pulses", err_cnt - err_base, 1);
    check_eq("bad_busy", busy, 0);
    do_write(8'h01, 32'h00000001, 0);
    wait_idle("wr2");
    check_eq("wr2_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check_eq("wr2_addr", wr_addr_q[0], 1);
      check_eq("wr2_data", wr_data_q[0], 1);
    end

    // Reset mid-command aborts it; the next byte is an opcode
    clear_obs();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_Address", Address, 0);
    check_eq("mid_rst_Data_in", Data_in, 0);
    check_eq("mid_rst_strobes", {write_En, read_En, tx_valid, cmd_err}, 0);
    rst = 1'b0;
    rd_base = rd_cnt;
    do_read(8'h02, 0);
    wait_idle("rd3");
    check_eq("rd3_read_count", rd_cnt - rd_base, 1);
    check_eq("rd3_no_write", wr_addr_q.size(), 0);
    check_eq("rd3_tx_word", tx_word(), model_mem[2]);

    // Randomized command mix against the model
    tx_mode = 2;
    for (int t = 0; t < 40; t++) begin
      int op;
      logic [7:0] a, b;
      logic [DW-1:0] d;
      bit junk;
      op   = $urandom_range(0, 9);
      a    = 8'($urandom);
      d    = $urandom;
      junk = 1'b1 & $urandom_range(0, 1);
      clear_obs();
      rd_base  = rd_cnt;
      err_base = err_cnt;
      if (op < 4) begin
        do_write(a, d, junk);
        wait_idle("rnd_wr");
        check_eq("rnd_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
          check_eq("rnd_wr_addr", wr_addr_q[0], a[AW-1:0]);
          check_eq("rnd_wr_data", wr_data_q[0], d);
        end
        check_eq("rnd_wr_no_tx", tx_q.size(), 0);
      end else if (op < 8) begin
        do_read(a, junk);
        wait_idle("rnd_rd");
        check_eq("rnd_rd_count", rd_cnt - rd_base, 1);
        check_eq("rnd_rd_tx_count", tx_q.size(), NBYTES);
        check_eq("rnd_rd_word", tx_word(), model_mem[a[AW-1:0]]);
        check_eq("rnd_rd_no_write", wr_addr_q.size(), 0);
      end else begin
        b = 8'($urandom);
        while (b == 8'hA5 || b == 8'h5A) b = 8'($urandom);
        send_byte(b);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rnd_bad_err", err_cnt - err_base, 1);
        check_eq("rnd_bad_quiet", wr_addr_q.size() + tx_q.size() + (rd_cnt - rd_base), 0);
      end
    end
    tx_mode = 0;

`ifdef MEM_CMD_CTRL_TIMEOUT_EN
    // Memory never answers: error 16 cycles after entering WAIT_VALID
    clear_obs();
    err_base = err_cnt;
    mem_stall = 1'b1;
    do_read(8'h05, 0);
    wait_idle("tmo");
    repeat (2) @(posedge clk);
    #1;
    check_eq("tmo_err_pulses", err_cnt - err_base, 1);
    check_eq("tmo_err_cycle", err_cyc - (rd_cyc + 1), 16);
    check_eq("tmo_no_tx", tx_q.size(), 0);
    check_eq("tmo_busy", busy, 0);
    mem_stall = 1'b0;
`endif

    check_eq("never_both_strobes", both_err, 0);
    check_eq("tx_stable_when_stalled", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_cmd_ctrl.md
MEM_CMD_CTRL -- requirements
Module: mem_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width; must be a multiple of 8.
REQ-002 SHALL have parameter MEM_DEPTH, default 64, memory word count; localparam ADDR_WIDTH = $clog2(MEM_DEPTH); localparam NBYTES = DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  command byte from UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_data  output  8  response byte to UART transmitter.
REQ-008 SHALL have port tx_valid  output  1  response byte valid; transfer when tx_valid and tx_ready are both high.
REQ-009 SHALL have port tx_ready  input  1  transmitter can accept a byte.
REQ-010 SHALL have ports write_En, read_En  output  1 each  memory strobes.
REQ-011 SHALL have ports Address  output  ADDR_WIDTH, and Data_in  output  DATA_WIDTH; both drive the memory.
REQ-012 SHALL have ports Data_out  input  DATA_WIDTH, and Valid_out  input  1; both are memory read returns.
REQ-013 SHALL have ports busy  output  1 (state not IDLE) and cmd_err  output  1 (one-cycle error pulse).

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, WDATA, WRITE, READ, WAIT_VALID, TX.
REQ-015 IDLE: rx_valid with opcode 0xA5 -> ADDR (write); 0x5A -> ADDR (read); any other opcode -> cmd_err pulse next cycle, remain IDLE.
REQ-016 ADDR: next rx_valid byte latched; low ADDR_WIDTH bits form Address, upper bits ignored; -> WDATA (write) or READ (read).
REQ-017 WDATA: collect NBYTES bytes MSB first into Data_in; byte counter 0..NBYTES-1; after last byte -> WRITE.
REQ-018 WRITE: write_En high exactly one cycle with stable Address/Data_in -> IDLE.
REQ-019 READ: read_En high exactly one cycle -> WAIT_VALID.
REQ-020 WAIT_VALID: on Valid_out high, capture Data_out into shift register -> TX; write_En/read_En low throughout.
REQ-021 TX: present NBYTES bytes MSB first; tx_valid held high and tx_data stable until tx_ready; after last handshake -> IDLE, tx_valid low.
REQ-022 rx_valid in WRITE, READ, WAIT_VALID or TX SHALL be dropped without side effect; busy high in these states.
REQ-023 write_En and read_En SHALL never be high in the same cycle.
REQ-024 Address and Data_in SHALL hold their last values outside strobe cycles.
REQ-025 Nominal latency: read_En at cycle T, Valid_out at T+1, first tx_valid at T+2.

Reset
REQ-026 rst high at any clock edge SHALL force IDLE, counters 0, and tx_data, tx_valid, write_En, read_En, Address, Data_in, busy, cmd_err all 0, aborting any command mid-operation.
REQ-027 The first byte after rst deassertion SHALL be decoded as an opcode.

Configuration
REQ-028 Macro MEM_CMD_CTRL_TIMEOUT_EN defined: WAIT_VALID counts cycles; if Valid_out is not seen within 16 cycles of entry, pulse cmd_err, send no response, -> IDLE.
REQ-029 Macro undefined: no timeout counter; WAIT_VALID waits indefinitely for Valid_out.

Verification
REQ-030 Bytes A5,03,DE,AD,BE,EF -> one write_En cycle, Address=3, Data_in=0xDEADBEEF, no tx_valid.
REQ-031 After REQ-030, bytes 5A,03 with memory model, tx_ready=1 -> read_En one cycle, tx bytes DE,AD,BE,EF in order, then busy=0.
REQ-032 Read with tx_ready toggled 1 of every 3 cycles -> tx_data stable while stalled, four bytes delivered exactly once each.
REQ-033 Byte 0x77 in IDLE -> single cmd_err pulse; then A5,01,00,00,00,01 -> normal write to address 1.
REQ-034 rst pulse after A5,02,11 -> all outputs 0; subsequent 5A,02 is decoded as a read, no write issued.
REQ-035 With MEM_CMD_CTRL_TIMEOUT_EN, Valid_out held 0 after read_En -> cmd_err 16 cycles after WAIT_VALID entry, no tx_valid, busy=0.
